bus_arbiter: RTL and testbench
==============================

# bus_arbiter

- Shares one external memory bus between instruction fetch (IF) and data access (MEM) in the 5-stage pipeline.
- Serializes the two requesters, with MEM having priority, and raises stall requests to the pipeline controller while an access is pending.
- Holds completed results until the consuming pipeline stage advances, and discards a fetch that is in flight when a flush arrives.
- Sits between the IF/MEM stages and the bus slave; its stall requests feed the controller that produces `stall[5:0]` and `flush`.

## Interface
Parameters:
- TIMEOUT, 255: number of WAIT cycles without `bus_ack` after which the access is abandoned (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  pipeline stall vector; [1] = IF/ID stall, [4] = MEM/WB stall
- flush  in  1  exception flush; pending and held IF results are discarded
- if_ce  in  1  fetch request, held at level until served
- if_addr  in  32  fetch address
- if_inst  out  32  fetched instruction
- stallreq_if  out  1  fetch not yet available
- mem_ce, mem_we  in  1 each  data request and write enable
- mem_addr  in  32  data address
- mem_sel  in  4  byte enables
- mem_wdata  in  32  write data
- mem_rdata  out  32  read data
- stallreq_mem  out  1  data access not yet complete
- bus_ce, bus_we  out  1 each  bus strobe and write enable
- bus_addr  out  32  bus address
- bus_sel  out  4  bus byte enables
- bus_wdata  out  32  bus write data
- bus_rdata  in  32  bus read data
- bus_ack  in  1  slave completion, single-cycle pulse
- bus_err  out  1  one-cycle pulse on timeout

## Operation
States: IDLE, IF_WAIT, MEM_WAIT.

- **IDLE:**
  - If `mem_ce & !mem_hold`: latch the MEM request (addr/we/sel/wdata) and go to MEM_WAIT.
  - Else if `if_ce & !if_hold`: latch `if_addr` (we=0, sel=4'b1111) and go to IF_WAIT.
- **WAIT states:**
  - `bus_*` outputs are driven from the latched request, with `bus_ce`=1.
  - On `bus_ack`, or when the timeout counter reaches TIMEOUT, return to IDLE.
  - In all other states `bus_ce`=0, `bus_we`=0, and the remaining bus outputs are 0.
- **Timeout:**
  - The counter is 8 bits, clears on entering a WAIT state, and increments every WAIT cycle.
  - On expiry the access completes with read data 0 and `bus_err`=1 for that cycle.
- **Completion cycle** (ack or timeout) for client X:
  - Result is `bus_rdata`, or 0 on timeout.
  - `X_rdata` = result, driven combinationally in that cycle.
  - `stallreq_X`=0 in that cycle.
  - If the consuming stage is stalled (`stall[1]`/`stall[4]` == Stop), set `X_hold`=1 and register the result in `X_hold_data`.
- **Held result:**
  - While `X_hold`=1: `X_rdata` = `X_hold_data`, `stallreq_X`=0, and no new bus access is started for X.
  - `X_hold` clears on the first edge at which the consuming stage is NoStop (the stage has consumed the result).
- **stallreq_X** = `X_ce & !X_hold & !(completion cycle for X)`.
- **Flush:**
  - Clears `if_hold`.
  - If in IF_WAIT (or entering it on that edge), set `if_abort`. On the completion of that access: return to IDLE, keep `stallreq_if`=1, do not set `if_hold`, and clear `if_abort`.
  - Flush does not affect MEM accesses or `mem_hold`.
- **Outside completion/hold:** `if_inst` and `mem_rdata` are 0.

## Timing
- Reset (`rst`=1 at an edge):
  - State goes to IDLE.
  - `if_hold`, `mem_hold`, `if_abort`, hold data, latched request and counter all go to 0.
  - All outputs are 0, including `stallreq_*`, because the `*_ce` inputs are reset low by their stages.
  - Reset mid-access abandons the transaction without pulsing `bus_err`.
- Minimum latency: request seen in IDLE at cycle n → `bus_ce` in cycle n+1 → ack in n+1 → result usable in n+1. This is 2 cycles.
- With W wait cycles before ack, latency is 2+W cycles.
- `bus_ack` while in IDLE is ignored.
- Simultaneous `if_ce` and `mem_ce` in IDLE: MEM is served first, IF waits, and `stallreq_if` stays 1 throughout.
- Back-to-back requests: IDLE is always visited for exactly one cycle between accesses.
- `flush` coinciding with an IF completion: the result is discarded and `stallreq_if`=1.

## Structure
- `defines.v` holds:
  - state encodings `ArbIdle`, `ArbIfWait`, `ArbMemWait`
  - default `ArbTimeout`
  - the existing `RstEnable`, `Stop`, `NoStop`, `ZeroWord`
- One sub-module, `arb_hold`, is instantiated twice (IF and MEM). It contains the hold flag and hold register, and the rdata/stallreq muxing for one client.
- The FSM, timeout counter and request latch live in `bus_arbiter`.

## Test plan
- **Single fetch:** `if_ce`=1, addr 0x100, ack one cycle after `bus_ce` with rdata 0x24020005 → `stallreq_if` high for 2 cycles; `if_inst`=0x24020005 in the ack cycle.
- **Contention:** `if_ce` and `mem_ce` rise together, MEM is a write of 0xDEADBEEF to 0x200 with sel 4'b1111 → MEM bus access occurs first with `bus_we`=1; IF access starts 2 cycles after the MEM ack.
- **Hold:** IF ack with rdata 0x1234 while `stall[1]`=Stop for 3 cycles → `if_inst`=0x1234 and `stallreq_if`=0 for all 3 cycles, no new `bus_ce`; hold clears at the first NoStop edge.
- **Flush in flight:** flush one cycle into IF_WAIT, ack 2 cycles later → `stallreq_if` stays 1; the next `if_ce` starts a new access.
- **Timeout:** TIMEOUT=4, no ack → `bus_ce` high for exactly 4 cycles, `bus_err` pulses once, `mem_rdata`=0 in the last WAIT cycle.
- **Reset mid-access:** `rst` asserted during MEM_WAIT → next cycle `bus_ce`=0, state IDLE, no `bus_err`.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM bus arbiter: FSM state encoding,
// default access timeout, pipeline stall levels and the latched bus request.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbIfWait  = 2'd1,
    ArbMemWait = 2'd2
  } arb_state_e;

  localparam int unsigned ArbTimeout = 255;

  localparam logic        RstEnable = 1'b1;
  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Request captured in IDLE and replayed on the bus for the whole access.
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_arbiter_hold.sv
// arb_hold: result hold and response muxing for one bus client (IF or MEM).
//   clk, rst     : clock, synchronous active-high reset
//   ce           : client request level
//   done         : completion cycle of this client's bus access
//   discard      : completion is to be thrown away (aborted fetch)
//   clear        : drop any held result (flush)
//   stage_stall  : stall level of the consuming pipeline stage
//   result       : completion data (bus read data, or zero on timeout)
//   rdata        : data presented to the client
//   stallreq     : client must keep waiting
//   hold         : a completed result is parked for the client
module arb_hold
  import bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        done,
  input  logic        discard,
  input  logic        clear,
  input  logic        stage_stall,
  input  logic [31:0] result,
  output logic [31:0] rdata,
  output logic        stallreq,
  output logic        hold
);

  logic        hold_q, hold_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic        accept;

  always_comb begin
    accept      = done & ~discard;
    hold_d      = hold_q;
    hold_data_d = hold_data_q;
    if (clear) begin
      hold_d = 1'b0;
    end else if (accept && stage_stall == Stop) begin
      hold_d      = 1'b1;
      hold_data_d = result;
    end else if (hold_q && stage_stall == NoStop) begin
      // Stage advanced on this edge, so the parked result has been consumed.
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hold_q      <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_data_q <= hold_data_d;
    end
  end

  always_comb begin
    if (hold_q) begin
      rdata = hold_data_q;
    end else if (accept) begin
      rdata = result;
    end else begin
      rdata = ZeroWord;
    end
    stallreq = ce & ~hold_q & ~accept;
    hold     = hold_q;
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between instruction fetch (IF) and data
// access (MEM). MEM has priority; each access is latched in IDLE, presented on
// the bus until bus_ack or timeout, and the result is handed back (and held
// while the consuming stage is stalled). Flush discards an in-flight fetch.
//   clk, rst            : clock, synchronous active-high reset
//   stall[5:0], flush   : pipeline controller stall vector and flush
//   if_ce, if_addr      : fetch request  -> if_inst, stallreq_if
//   mem_ce/we/addr/sel/wdata : data request -> mem_rdata, stallreq_mem
//   bus_ce/we/addr/sel/wdata : bus master outputs
//   bus_rdata, bus_ack  : bus slave response
//   bus_err             : one-cycle pulse when an access times out
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = ArbTimeout
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        if_ce,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        stallreq_if,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        stallreq_mem,
  output logic        bus_ce,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  arb_state_e  state_q, state_d;
  bus_req_t    req_q, req_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        if_abort_q, if_abort_d;

  logic        in_wait, to_done, done, if_done, mem_done;
  logic [31:0] result;
  logic        if_hold, mem_hold;
  logic        unused_stall_bits;

  assign unused_stall_bits = ^{stall[5], stall[3:2], stall[0]};

  // Counter holds the number of WAIT cycles already completed, so the
  // TIMEOUT-th WAIT cycle is the one that sees TimeoutLast.
  always_comb begin
    in_wait  = (state_q != ArbIdle);
    to_done  = in_wait & ~bus_ack & (cnt_q == TimeoutLast);
    done     = in_wait & (bus_ack | to_done);
    if_done  = done & (state_q == ArbIfWait);
    mem_done = done & (state_q == ArbMemWait);
    result   = bus_ack ? bus_rdata : ZeroWord;
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    if_abort_d = if_abort_q;
    unique case (state_q)
      ArbIdle: begin
        cnt_d = '0;
        if (mem_ce && !mem_hold) begin
          req_d   = '{we: mem_we, sel: mem_sel, addr: mem_addr, wdata: mem_wdata};
          state_d = ArbMemWait;
        end else if (if_ce && !if_hold) begin
          req_d   = '{we: 1'b0, sel: '1, addr: if_addr, wdata: ZeroWord};
          state_d = ArbIfWait;
          if (flush) begin
            if_abort_d = 1'b1;
          end
        end
      end
      ArbIfWait: begin
        cnt_d = cnt_q + 8'd1;
        if (done) begin
          state_d    = ArbIdle;
          cnt_d      = '0;
          if_abort_d = 1'b0;
        end else if (flush) begin
          if_abort_d = 1'b1;
        end
      end
      ArbMemWait: begin
        cnt_d = cnt_q + 8'd1;
        if (done) begin
          state_d = ArbIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ArbIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= ArbIdle;
      req_q      <= '0;
      cnt_q      <= '0;
      if_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      if_abort_q <= if_abort_d;
    end
  end

  always_comb begin
    bus_ce    = in_wait;
    bus_we    = in_wait & req_q.we;
    bus_addr  = in_wait ? req_q.addr  : ZeroWord;
    bus_sel   = in_wait ? req_q.sel   : '0;
    bus_wdata = in_wait ? req_q.wdata : ZeroWord;
    bus_err   = to_done;
  end

  // A flush in the completion cycle itself must also discard the fetch.
  arb_hold u_if_hold (
    .clk         (clk),
    .rst         (rst),
    .ce          (if_ce),
    .done        (if_done),
    .discard     (if_abort_q | flush),
    .clear       (flush),
    .stage_stall (stall[1]),
    .result      (result),
    .rdata       (if_inst),
    .stallreq    (stallreq_if),
    .hold        (if_hold)
  );

  arb_hold u_mem_hold (
    .clk         (clk),
    .rst         (rst),
    .ce          (mem_ce),
    .done        (mem_done),
    .discard     (1'b0),
    .clear       (1'b0),
    .stage_stall (stall[4]),
    .result      (result),
    .rdata       (mem_rdata),
    .stallreq    (stallreq_mem),
    .hold        (mem_hold)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: per-cycle expectation timelines built from the
// transaction rules (order, wait counts, hold lengths), a directed vector
// table with hand-derived summary figures, hand-written flush/reset
// sequences and randomized transactions.
module tb_bus_arbiter;

  localparam int unsigned TO   = 4;
  localparam int unsigned MAXC = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        stallreq_if;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stallreq_mem;
  logic        bus_ce, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_ce(if_ce), .if_addr(if_addr), .if_inst(if_inst), .stallreq_if(stallreq_if),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stallreq_mem(stallreq_mem),
    .bus_ce(bus_ce), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  typedef struct packed {
    logic        sr_if;
    logic        sr_mem;
    logic        ce;
    logic        we;
    logic        err;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] inst;
    logic [31:0] rdata;
  } obs_t;

  typedef struct {
    bit          use_if;
    bit          use_mem;
    logic [31:0] if_addr;
    logic [31:0] if_rd;
    int unsigned w_if;
    logic [31:0] mem_addr;
    bit          mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rd;
    int unsigned w_mem;
    int unsigned hold;
    int unsigned x_sr_if;
    int unsigned x_sr_mem;
    int unsigned x_ce;
    int unsigned x_err;
    int unsigned x_start;
  } vec_t;

  obs_t        exp_o     [MAXC];
  logic        s_rst     [MAXC];
  logic        s_flush   [MAXC];
  logic        s_if_ce   [MAXC];
  logic        s_mem_ce  [MAXC];
  logic        s_ack     [MAXC];
  logic        s_st1     [MAXC];
  logic        s_st4     [MAXC];
  logic [31:0] s_if_addr [MAXC];
  logic [31:0] s_rdata   [MAXC];
  logic        s_mem_we;
  logic [3:0]  s_mem_sel;
  logic [31:0] s_mem_addr, s_mem_wdata;
  int unsigned seq_len;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned m_sr_if, m_sr_mem, m_ce, m_err, m_rise;

  vec_t tbl [8];

  task automatic clear_seq();
    for (int unsigned i = 0; i < MAXC; i++) begin
      exp_o[i]     = '0;
      s_rst[i]     = 1'b0;
      s_flush[i]   = 1'b0;
      s_if_ce[i]   = 1'b0;
      s_mem_ce[i]  = 1'b0;
      s_ack[i]     = 1'b0;
      s_st1[i]     = 1'b0;
      s_st4[i]     = 1'b0;
      s_if_addr[i] = '0;
      s_rdata[i]   = $urandom;
    end
    s_mem_we    = 1'b0;
    s_mem_sel   = '0;
    s_mem_addr  = '0;
    s_mem_wdata = '0;
  endtask

  task automatic exp_bus(input int unsigned k, input logic [31:0] a, input logic we,
                         input logic [3:0] sel, input logic [31:0] wd);
    exp_o[k].ce    = 1'b1;
    exp_o[k].we    = we;
    exp_o[k].sel   = sel;
    exp_o[k].addr  = a;
    exp_o[k].wdata = wd;
  endtask

  task automatic check_val(input string nm, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic run_seq(input string nm);
    obs_t       act;
    logic [5:0] st;
    logic       prev_ce;
    m_sr_if = 0; m_sr_mem = 0; m_ce = 0; m_err = 0; m_rise = 0;
    prev_ce = 1'b0;
    for (int unsigned k = 0; k < seq_len; k++) begin
      @(posedge clk);
      #1;
      rst       = s_rst[k];
      flush     = s_flush[k];
      if_ce     = s_if_ce[k];
      if_addr   = s_if_addr[k];
      mem_ce    = s_mem_ce[k];
      mem_we    = s_mem_we;
      mem_addr  = s_mem_addr;
      mem_sel   = s_mem_sel;
      mem_wdata = s_mem_wdata;
      bus_ack   = s_ack[k];
      bus_rdata = s_rdata[k];
      st        = 6'($urandom);
      st[1]     = s_st1[k];
      st[4]     = s_st4[k];
      stall     = st;
      @(negedge clk);
      act = {stallreq_if, stallreq_mem, bus_ce, bus_we, bus_err, bus_sel,
             bus_addr, bus_wdata, if_inst, mem_rdata};
      checks++;
      if (act !== exp_o[k]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", nm, k, act, exp_o[k]);
      end
      if (stallreq_if)  m_sr_if++;
      if (stallreq_mem) m_sr_mem++;
      if (bus_ce)       m_ce++;
      if (bus_err)      m_err++;
      if (bus_ce && !prev_ce) m_rise = k;
      prev_ce = bus_ce;
    end
  endtask

  // Timeline of one transaction: both clients raise ce in cycle 0, MEM is
  // served first, each service is one IDLE cycle then min(W, TO-1)+1 WAIT
  // cycles; W >= TO means no ack and a timeout in the last WAIT cycle.
  task automatic build_txn(input vec_t v);
    int unsigned s, c, e, h, last;
    bit          to;
    bit          busy [MAXC];
    clear_seq();
    for (int unsigned i = 0; i < MAXC; i++) busy[i] = 1'b0;
    s_mem_we    = v.mem_we;
    s_mem_sel   = v.mem_sel;
    s_mem_addr  = v.mem_addr;
    s_mem_wdata = v.mem_wdata;
    s = 0;
    last = 0;
    if (v.use_mem) begin
      to = (v.w_mem >= TO);
      e  = to ? TO - 1 : v.w_mem;
      c  = s + 1 + e;
      h  = v.use_if ? 0 : v.hold;
      for (int unsigned k = s + 1; k <= c; k++) begin
        exp_bus(k, v.mem_addr, v.mem_we, v.mem_sel, v.mem_wdata);
        busy[k] = 1'b1;
      end
      if (!to) begin
        s_ack[c]   = 1'b1;
        s_rdata[c] = v.mem_rd;
      end
      exp_o[c].err = to;
      for (int unsigned k = 0; k <= c + h; k++) s_mem_ce[k] = 1'b1;
      for (int unsigned k = 0; k < c; k++)      exp_o[k].sr_mem = 1'b1;
      for (int unsigned k = c; k <= c + h; k++) exp_o[k].rdata = to ? 32'h0 : v.mem_rd;
      for (int unsigned k = c; k < c + h; k++)  s_st4[k] = 1'b1;
      s = c + h + 1;
      last = c + h;
    end
    if (v.use_if) begin
      to = (v.w_if >= TO);
      e  = to ? TO - 1 : v.w_if;
      c  = s + 1 + e;
      h  = v.use_mem ? 0 : v.hold;
      for (int unsigned k = s + 1; k <= c; k++) begin
        exp_bus(k, v.if_addr, 1'b0, 4'hF, 32'h0);
        busy[k] = 1'b1;
      end
      if (!to) begin
        s_ack[c]   = 1'b1;
        s_rdata[c] = v.if_rd;
      end
      exp_o[c].err = to;
      for (int unsigned k = 0; k <= c + h; k++) begin
        s_if_ce[k]   = 1'b1;
        s_if_addr[k] = v.if_addr;
      end
      for (int unsigned k = 0; k < c; k++)      exp_o[k].sr_if = 1'b1;
      for (int unsigned k = c; k <= c + h; k++) exp_o[k].inst = to ? 32'h0 : v.if_rd;
      for (int unsigned k = c; k < c + h; k++)  s_st1[k] = 1'b1;
      last = c + h;
    end
    seq_len = last + 2;
    // Stray acks while the arbiter is idle must have no effect.
    for (int unsigned k = 0; k < seq_len; k++)
      if (!busy[k] && $urandom_range(3) == 0) s_ack[k] = 1'b1;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; flush = 1'b0; stall = '0;
    if_ce = 1'b0; if_addr = '0;
    mem_ce = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state, including a stray ack right after reset.
    clear_seq();
    s_rst[0] = 1'b1;
    s_ack[1] = 1'b1;
    seq_len  = 2;
    run_seq("reset");

    //          if  mem if_addr       if_rd         wif mem_addr      we sel   wdata          mem_rd        wm hold sri srm ce err start
    tbl[0] = '{1, 0, 32'h0000_0100, 32'h2402_0005, 1, 32'h0,         0, 4'h0, 32'h0,         32'h0,         0, 0,   2,  0,  2, 0,  1};
    tbl[1] = '{1, 1, 32'h0000_0104, 32'h0000_0013, 0, 32'h0000_0200, 1, 4'hF, 32'hDEAD_BEEF, 32'h0,         0, 0,   3,  1,  2, 0,  3};
    tbl[2] = '{1, 0, 32'h0000_0108, 32'h0000_1234, 0, 32'h0,         0, 4'h0, 32'h0,         32'h0,         0, 3,   1,  0,  1, 0,  1};
    tbl[3] = '{0, 1, 32'h0,         32'h0,         0, 32'h0000_0300, 0, 4'hF, 32'h0,         32'h0000_0099, 4, 0,   0,  4,  4, 1,  1};
    tbl[4] = '{0, 1, 32'h0,         32'h0,         0, 32'h0000_0304, 0, 4'h3, 32'h0,         32'hCAFE_F00D, 3, 0,   0,  4,  4, 0,  1};
    tbl[5] = '{0, 1, 32'h0,         32'h0,         0, 32'h0000_0308, 1, 4'h1, 32'h0000_00A5, 32'h0000_55AA, 2, 2,   0,  3,  3, 0,  1};
    tbl[6] = '{1, 1, 32'h0000_010C, 32'h0000_0077, 1, 32'h0000_030C, 0, 4'hC, 32'h0,         32'h0000_0088, 2, 0,   6,  3,  5, 0,  5};
    tbl[7] = '{1, 0, 32'h0000_0110, 32'h0000_0066, 4, 32'h0,         0, 4'h0, 32'h0,         32'h0,         0, 0,   4,  0,  4, 1,  1};

    for (int unsigned i = 0; i < 8; i++) begin
      build_txn(tbl[i]);
      run_seq($sformatf("vec%0d", i));
      check_val($sformatf("vec%0d stallreq_if cycles", i), m_sr_if, tbl[i].x_sr_if);
      check_val($sformatf("vec%0d stallreq_mem cycles", i), m_sr_mem, tbl[i].x_sr_mem);
      check_val($sformatf("vec%0d bus_ce cycles", i), m_ce, tbl[i].x_ce);
      check_val($sformatf("vec%0d bus_err pulses", i), m_err, tbl[i].x_err);
      check_val($sformatf("vec%0d last access start", i), m_rise, tbl[i].x_start);
    end

    // Flush one cycle into IF_WAIT, ack two cycles later, then a refetch.
    clear_seq();
    for (int unsigned k = 0; k <= 6; k++) begin
      s_if_ce[k]   = 1'b1;
      s_if_addr[k] = (k < 5) ? 32'h0000_0500 : 32'h0000_0400;
    end
    for (int unsigned k = 0; k <= 5; k++) exp_o[k].sr_if = 1'b1;
    for (int unsigned k = 1; k <= 4; k++) exp_bus(k, 32'h0000_0500, 1'b0, 4'hF, 32'h0);
    s_flush[2] = 1'b1;
    s_ack[4] = 1'b1; s_rdata[4] = 32'h0000_0BAD;
    exp_bus(6, 32'h0000_0400, 1'b0, 4'hF, 32'h0);
    s_ack[6] = 1'b1; s_rdata[6] = 32'h0000_0777;
    exp_o[6].inst = 32'h0000_0777;
    seq_len = 8;
    run_seq("flush_in_flight");

    // Flush in the IF completion cycle while IF/ID is stalled.
    clear_seq();
    for (int unsigned k = 0; k <= 3; k++) begin
      s_if_ce[k]   = 1'b1;
      s_if_addr[k] = (k < 2) ? 32'h0000_0600 : 32'h0000_0604;
    end
    for (int unsigned k = 0; k <= 2; k++) exp_o[k].sr_if = 1'b1;
    exp_bus(1, 32'h0000_0600, 1'b0, 4'hF, 32'h0);
    s_ack[1] = 1'b1; s_rdata[1] = 32'h0000_0111; s_flush[1] = 1'b1; s_st1[1] = 1'b1;
    exp_bus(3, 32'h0000_0604, 1'b0, 4'hF, 32'h0);
    s_ack[3] = 1'b1; s_rdata[3] = 32'h0000_0222;
    exp_o[3].inst = 32'h0000_0222;
    seq_len = 5;
    run_seq("flush_at_ack");

    // Flush drops a held fetch result even though IF/ID stays stalled.
    clear_seq();
    for (int unsigned k = 0; k <= 4; k++) begin
      s_if_ce[k]   = 1'b1;
      s_if_addr[k] = (k < 3) ? 32'h0000_0700 : 32'h0000_0704;
    end
    exp_o[0].sr_if = 1'b1;
    exp_bus(1, 32'h0000_0700, 1'b0, 4'hF, 32'h0);
    s_ack[1] = 1'b1; s_rdata[1] = 32'h0000_0333;
    s_st1[1] = 1'b1; s_st1[2] = 1'b1; s_st1[3] = 1'b1;
    exp_o[1].inst = 32'h0000_0333;
    exp_o[2].inst = 32'h0000_0333;
    s_flush[2] = 1'b1;
    exp_o[3].sr_if = 1'b1;
    exp_bus(4, 32'h0000_0704, 1'b0, 4'hF, 32'h0);
    s_ack[4] = 1'b1; s_rdata[4] = 32'h0000_0444;
    exp_o[4].inst = 32'h0000_0444;
    seq_len = 6;
    run_seq("flush_clears_hold");

    // Reset during MEM_WAIT abandons the access silently.
    clear_seq();
    s_mem_we = 1'b1; s_mem_sel = 4'h3; s_mem_addr = 32'h0000_0800; s_mem_wdata = 32'h0000_1111;
    for (int unsigned k = 0; k <= 2; k++) begin
      s_mem_ce[k] = 1'b1;
      exp_o[k].sr_mem = 1'b1;
    end
    exp_bus(1, 32'h0000_0800, 1'b1, 4'h3, 32'h0000_1111);
    exp_bus(2, 32'h0000_0800, 1'b1, 4'h3, 32'h0000_1111);
    s_rst[2] = 1'b1;
    s_ack[3] = 1'b1;
    s_if_ce[4] = 1'b1; s_if_addr[4] = 32'h0000_0900;
    s_if_ce[5] = 1'b1; s_if_addr[5] = 32'h0000_0900;
    exp_o[4].sr_if = 1'b1;
    exp_bus(5, 32'h0000_0900, 1'b0, 4'hF, 32'h0);
    s_ack[5] = 1'b1; s_rdata[5] = 32'h0000_0005;
    exp_o[5].inst = 32'h0000_0005;
    seq_len = 7;
    run_seq("reset_mid_access");

    // Randomized transactions.
    for (int unsigned n = 0; n < 200; n++) begin
      v.use_mem   = 1'($urandom_range(1));
      v.use_if    = v.use_mem ? 1'($urandom_range(1)) : 1'b1;
      v.if_addr   = $urandom & 32'hFFFF_FFFC;
      v.if_rd     = $urandom;
      v.w_if      = $urandom_range(TO);
      v.mem_addr  = $urandom & 32'hFFFF_FFFC;
      v.mem_we    = 1'($urandom_range(1));
      v.mem_sel   = 4'($urandom);
      v.mem_wdata = $urandom;
      v.mem_rd    = $urandom;
      v.w_mem     = $urandom_range(TO);
      v.hold      = (v.use_if && v.use_mem) ? 0 : $urandom_range(3);
      v.x_sr_if = 0; v.x_sr_mem = 0; v.x_ce = 0; v.x_err = 0; v.x_start = 0;
      build_txn(v);
      run_seq($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
